// File: rtl/watch_pkg.sv
// Purpose: shared types, field limits and field-edit helpers for the watch time-set path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam int FIELD_W = 6;
    localparam logic [FIELD_W-1:0] HORAS_MAX = 6'd23;
    localparam logic [FIELD_W-1:0] MIN_MAX   = 6'd59;

    // Bit positions inside blink_mask = {hours, minutes, seconds}.
    localparam int BM_H = 2;
    localparam int BM_M = 1;
    localparam int BM_S = 0;

    // Shadow time as one packed bundle.
    typedef struct packed {
        logic [FIELD_W-1:0] horas;
        logic [FIELD_W-1:0] minutos;
        logic [FIELD_W-1:0] segundos;
    } hms_t;

    // Out-of-range values (possible if Watch hands us garbage) fold back into range.
    function automatic logic [FIELD_W-1:0] inc_wrap(input logic [FIELD_W-1:0] v,
                                                    input logic [FIELD_W-1:0] max);
        return (v >= max) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [FIELD_W-1:0] dec_wrap(input logic [FIELD_W-1:0] v,
                                                    input logic [FIELD_W-1:0] max);
        return (v == '0 || v > max) ? max : v - 1'b1;
    endfunction

    // blink_mask bit belonging to the field edited in a given state.
    function automatic logic [2:0] field_mask(input state_t s);
        logic [2:0] m;
        m = '0;
        case (s)
            SET_H:   m[BM_H] = 1'b1;
            SET_M:   m[BM_M] = 1'b1;
            SET_S:   m[BM_S] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/btn_event.sv
// Purpose: rising-edge event from a debounced button level, with optional hold-to-repeat.
// Latency: evt is combinational in the cycle the 0->1 (or repeat point) is sampled.
// Backpressure: none; events are single-cycle pulses and are never queued.
// Ports: clk, rst (sync, active-high); level = button level in; evt = one-cycle event out.
module btn_event #(
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic evt
);

    logic        prev;
    logic        armed;   // set only by a genuine press, so a level held through reset never repeats
    logic        first;   // waiting for the initial REPEAT_DELAY rather than REPEAT_PERIOD
    logic [31:0] cnt;     // cycles held since the last event
    logic        press;
    logic        rpt;

    assign press = level & ~prev;
    assign rpt   = REPEAT_EN && armed && level && prev &&
                   (first ? (cnt == REPEAT_DELAY) : (cnt == REPEAT_PERIOD));
    assign evt   = press | rpt;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b1;
            armed <= 1'b0;
            first <= 1'b1;
            cnt   <= '0;
        end else begin
            prev <= level;
            if (!level) begin
                armed <= 1'b0;
            end else if (press) begin
                armed <= REPEAT_EN;
                first <= 1'b1;
                cnt   <= 32'd1;
            end else if (rpt) begin
                first <= 1'b0;
                cnt   <= 32'd1;
            end else if (armed) begin
                cnt   <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/watch_set_controller.sv
// Purpose: button-driven time-set sequencer: capture Watch time, edit h/m/s, load it back.
// Latency: one clk from a sampled button event to the registered outputs; load is a 1-cycle strobe.
// Backpressure: none; Watch must accept load on the strobe cycle (load beats tick there).
// Ports: clk, rst (sync, active-high); btn_mode/btn_up/btn_down levels; horas/minutos/segundos_in
//        from Watch; load + *_load shadow values to Watch; run_en gates the 1 Hz tick;
//        blink_mask {h,m,s} and editing to HORA_DISPLAY.
// Build option: define AUTO_REPEAT_EN to make held up/down buttons auto-repeat.
module watch_set_controller
    import watch_pkg::*;
#(
    parameter int unsigned BLINK_HALF    = 50_000_000,
    parameter int unsigned IDLE_TIMEOUT  = 1_000_000_000,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_mode,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic [FIELD_W-1:0] horas_in,
    input  logic [FIELD_W-1:0] minutos_in,
    input  logic [FIELD_W-1:0] segundos_in,
    output logic               load,
    output logic [FIELD_W-1:0] horas_load,
    output logic [FIELD_W-1:0] minutos_load,
    output logic [FIELD_W-1:0] segundos_load,
    output logic               run_en,
    output logic [2:0]         blink_mask,
    output logic               editing
);

`ifdef AUTO_REPEAT_EN
    localparam bit UD_REPEAT = 1'b1;
`else
    localparam bit UD_REPEAT = 1'b0;
`endif

    state_t      state;
    hms_t        shadow;
    logic [31:0] blink_cnt;
    logic        blink_ph;
    logic [31:0] idle_cnt;

    logic ev_mode, ev_up, ev_down;
    logic edit_up, edit_dn;

    btn_event #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_mode (.clk(clk), .rst(rst), .level(btn_mode), .evt(ev_mode));
    btn_event #(.REPEAT_EN(UD_REPEAT), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_up   (.clk(clk), .rst(rst), .level(btn_up),   .evt(ev_up));
    btn_event #(.REPEAT_EN(UD_REPEAT), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_down (.clk(clk), .rst(rst), .level(btn_down), .evt(ev_down));

    // Up and down together cancel; mode priority is handled by branch order below.
    assign edit_up = ev_up & ~ev_down;
    assign edit_dn = ev_down & ~ev_up;

    assign horas_load    = shadow.horas;
    assign minutos_load  = shadow.minutos;
    assign segundos_load = shadow.segundos;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            shadow     <= '0;
            load       <= 1'b0;
            run_en     <= 1'b1;
            editing    <= 1'b0;
            blink_mask <= 3'b000;
            blink_cnt  <= '0;
            blink_ph   <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            load <= 1'b0;
            case (state)
                RUN: begin
                    idle_cnt   <= '0;
                    blink_cnt  <= '0;
                    blink_ph   <= 1'b0;
                    blink_mask <= 3'b000;
                    if (ev_mode) begin
                        state   <= SET_H;
                        shadow  <= '{horas: horas_in, minutos: minutos_in, segundos: segundos_in};
                        run_en  <= 1'b0;
                        editing <= 1'b1;
                    end
                end

                default: begin
                    if (ev_mode) begin
                        idle_cnt   <= '0;
                        blink_cnt  <= '0;
                        blink_ph   <= 1'b0;
                        blink_mask <= 3'b000;
                        case (state)
                            SET_H:   state <= SET_M;
                            SET_M:   state <= SET_S;
                            default: begin
                                state   <= RUN;
                                load    <= 1'b1;
                                run_en  <= 1'b1;
                                editing <= 1'b0;
                            end
                        endcase
                    end else if (ev_up || ev_down) begin
                        // Restart the blink so the freshly edited field is shown at once.
                        idle_cnt   <= '0;
                        blink_cnt  <= '0;
                        blink_ph   <= 1'b0;
                        blink_mask <= 3'b000;
                        case (state)
                            SET_H: begin
                                if (edit_up)      shadow.horas <= inc_wrap(shadow.horas, HORAS_MAX);
                                else if (edit_dn) shadow.horas <= dec_wrap(shadow.horas, HORAS_MAX);
                            end
                            SET_M: begin
                                if (edit_up)      shadow.minutos <= inc_wrap(shadow.minutos, MIN_MAX);
                                else if (edit_dn) shadow.minutos <= dec_wrap(shadow.minutos, MIN_MAX);
                            end
                            default: begin
                                if (edit_up || edit_dn) shadow.segundos <= '0;
                            end
                        endcase
                    end else if (idle_cnt == IDLE_TIMEOUT - 1) begin
                        // Abandon the edit: no load, Watch resumes from its own count.
                        state      <= RUN;
                        run_en     <= 1'b1;
                        editing    <= 1'b0;
                        idle_cnt   <= '0;
                        blink_cnt  <= '0;
                        blink_ph   <= 1'b0;
                        blink_mask <= 3'b000;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                        if (blink_cnt == BLINK_HALF - 1) begin
                            blink_cnt  <= '0;
                            blink_ph   <= ~blink_ph;
                            blink_mask <= blink_ph ? 3'b000 : field_mask(state);
                        end else begin
                            blink_cnt <= blink_cnt + 32'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
